// File: rtl/dpram_arbiter_pkg.sv
// dpram_arbiter_pkg: shared widths, response FIFO depth and requester index type
package dpram_arbiter_pkg;
  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int RSP_FIFO_DEPTH = 2;
  localparam int RSP_CNT_W = $clog2(RSP_FIFO_DEPTH + 1);
  typedef enum logic {REQ_W0 = 1'b0, REQ_W1 = 1'b1} req_idx_t;
endpackage

// File: rtl/dpram_rsp_fifo.sv
// dpram_rsp_fifo: two-entry read response FIFO; head reads as zero when empty
module dpram_rsp_fifo
  import dpram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [RSP_CNT_W-1:0]  count
);
  logic [RSP_FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
  logic                 rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, do_pop;
  logic [RSP_CNT_W-1:0] count_q, count_d;
  // next-state: simultaneous push and pop leaves the count unchanged
  always_comb begin
    do_pop = pop && count_q != '0;
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = do_pop ? ~rd_ptr_q : rd_ptr_q;
    count_d = count_q + RSP_CNT_W'(push) - RSP_CNT_W'(do_pop);
    head = count_q != '0 ? mem_q[rd_ptr_q] : '0;
    count = count_q;
  end
  // state registers, contents cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/dpram_arbiter.sv
// dpram_arbiter: two-writer / one-reader RAM port arbiter; DPRAM_ARBITER_RR_EN selects round-robin write contention
module dpram_arbiter
  import dpram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  W0_VALID,
  output logic                  W0_READY,
  input  logic [ADDR_WIDTH-1:0] W0_ADDR,
  input  logic [DATA_WIDTH-1:0] W0_DATA,
  input  logic                  W1_VALID,
  output logic                  W1_READY,
  input  logic [ADDR_WIDTH-1:0] W1_ADDR,
  input  logic [DATA_WIDTH-1:0] W1_DATA,
  input  logic                  AR_VALID,
  output logic                  AR_READY,
  input  logic [ADDR_WIDTH-1:0] AR_ADDR,
  output logic                  R_VALID,
  input  logic                  R_READY,
  output logic [DATA_WIDTH-1:0] R_DATA,
  output logic                  RAM_WVALID,
  output logic [ADDR_WIDTH-1:0] RAM_WADDR,
  output logic [DATA_WIDTH-1:0] RAM_WDATA,
  output logic                  RAM_ARVALID,
  output logic [ADDR_WIDTH-1:0] RAM_ARADDR,
  input  logic                  RAM_RVALID,
  input  logic [DATA_WIDTH-1:0] RAM_RDATA
);
  req_idx_t             sel;
  logic                 inflight_q, inflight_d, push, pop, collision;
  logic [RSP_CNT_W-1:0] count;
  logic [RSP_CNT_W:0]   occupancy;
`ifdef DPRAM_ARBITER_RR_EN
  req_idx_t rr_q, rr_d;
  // contention goes to the pointer; any grant hands priority to the other requester
  always_comb begin
    sel = W0_VALID && W1_VALID ? rr_q : (W1_VALID ? REQ_W1 : REQ_W0);
    rr_d = W0_VALID || W1_VALID ? req_idx_t'(~sel) : rr_q;
  end
  // round-robin pointer, requester 0 first after reset
  always_ff @(posedge CLK) begin
    if (RESET) rr_q <= REQ_W0;
    else rr_q <= rr_d;
  end
`else
  // fixed priority: requester 0 wins contention
  always_comb sel = W1_VALID && !W0_VALID ? REQ_W1 : REQ_W0;
`endif
  // write grant and RAM write port mux, zero when nothing is granted
  always_comb begin
    W0_READY = W0_VALID && sel == REQ_W0;
    W1_READY = W1_VALID && sel == REQ_W1;
    RAM_WVALID = W0_VALID || W1_VALID;
    RAM_WADDR = W0_READY ? W0_ADDR : W1_READY ? W1_ADDR : '0;
    RAM_WDATA = W0_READY ? W0_DATA : W1_READY ? W1_DATA : '0;
  end
  // read acceptance: leave room for every outstanding response and defer reads hitting this cycle's write
  always_comb begin
    pop = R_VALID && R_READY;
    collision = RAM_WVALID && RAM_WADDR == AR_ADDR;
    occupancy = {1'b0, count} + (RSP_CNT_W + 1)'(inflight_q) - (RSP_CNT_W + 1)'(pop);
    AR_READY = occupancy < (RSP_CNT_W + 1)'(RSP_FIFO_DEPTH) && !collision;
    RAM_ARVALID = AR_VALID && AR_READY;
    RAM_ARADDR = AR_ADDR;
    inflight_d = RAM_ARVALID;
    push = RAM_RVALID && inflight_q;
    R_VALID = count != '0;
  end
  // one-cycle read-in-flight marker; reset drops any pending RAM response
  always_ff @(posedge CLK) begin
    if (RESET) inflight_q <= 1'b0;
    else inflight_q <= inflight_d;
  end
  dpram_rsp_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_rsp_fifo (
    .clk      (CLK),
    .rst      (RESET),
    .push     (push),
    .push_data(RAM_RDATA),
    .pop      (pop),
    .head     (R_DATA),
    .count    (count)
  );
endmodule

// File: tb/tb_dpram_arbiter.sv
// tb_dpram_arbiter: directed self-checking bench with a one-cycle-latency RAM model
module tb_dpram_arbiter;
  logic        CLK, RESET;
  logic        W0_VALID, W0_READY, W1_VALID, W1_READY;
  logic [10:0] W0_ADDR, W1_ADDR, AR_ADDR, RAM_WADDR, RAM_ARADDR;
  logic [15:0] W0_DATA, W1_DATA, R_DATA, RAM_WDATA, RAM_RDATA;
  logic        AR_VALID, AR_READY, R_VALID, R_READY;
  logic        RAM_WVALID, RAM_ARVALID, RAM_RVALID;
  logic [15:0] mem [0:2047];
  logic        ram_rv, spur;
  logic [15:0] ram_rd;
  logic [3:0]  exp_w0;
  int          passed = 0, total = 0;

  dpram_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .W0_VALID(W0_VALID), .W0_READY(W0_READY), .W0_ADDR(W0_ADDR), .W0_DATA(W0_DATA),
    .W1_VALID(W1_VALID), .W1_READY(W1_READY), .W1_ADDR(W1_ADDR), .W1_DATA(W1_DATA),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA),
    .RAM_WVALID(RAM_WVALID), .RAM_WADDR(RAM_WADDR), .RAM_WDATA(RAM_WDATA),
    .RAM_ARVALID(RAM_ARVALID), .RAM_ARADDR(RAM_ARADDR),
    .RAM_RVALID(RAM_RVALID), .RAM_RDATA(RAM_RDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM model: mem[a] = 0x1000 + a after reset, one-cycle read latency
  always @(posedge CLK) begin
    if (RESET) for (int i = 0; i < 2048; i++) mem[i] <= 16'(16'h1000 + i);
    else if (RAM_WVALID) mem[RAM_WADDR] <= RAM_WDATA;
    ram_rv <= RAM_ARVALID;
    ram_rd <= mem[RAM_ARADDR];
  end
  assign RAM_RVALID = ram_rv | spur;
  assign RAM_RDATA = spur ? 16'hDEAD : ram_rd;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1; spur = 1'b0; R_READY = 1'b0;
    W0_VALID = 0; W0_ADDR = '0; W0_DATA = '0;
    W1_VALID = 0; W1_ADDR = '0; W1_DATA = '0;
    AR_VALID = 0; AR_ADDR = '0;
    repeat (2) tick();
    RESET = 1'b0;
    #1;
    chk("rst_rvalid", 16'(R_VALID), 16'h0);
    chk("rst_rdata", R_DATA, 16'h0);
    chk("rst_arready", 16'(AR_READY), 16'h1);
    chk("rst_wvalid", 16'(RAM_WVALID), 16'h0);
    chk("rst_waddr", 16'(RAM_WADDR), 16'h0);
    chk("rst_wready", 16'({W0_READY, W1_READY}), 16'h0);
    // single writers
    tick();
    W0_VALID = 1; W0_ADDR = 11'd3; W0_DATA = 16'h1111;
    #1;
    chk("w0_only_ready", 16'({W0_READY, W1_READY}), 16'h2);
    chk("w0_only_addr", 16'(RAM_WADDR), 16'h3);
    chk("w0_only_data", RAM_WDATA, 16'h1111);
    tick();
    W0_VALID = 0; W1_VALID = 1; W1_ADDR = 11'd4; W1_DATA = 16'h2222;
    #1;
    chk("w1_only_ready", 16'({W0_READY, W1_READY}), 16'h1);
    chk("w1_only_addr", 16'(RAM_WADDR), 16'h4);
    chk("w1_only_data", RAM_WDATA, 16'h2222);
    // contention for 4 cycles
`ifdef DPRAM_ARBITER_RR_EN
    exp_w0 = 4'b0101;
`else
    exp_w0 = 4'b1111;
`endif
    tick();
    W0_VALID = 1; W0_ADDR = 11'd10; W0_DATA = 16'hAAAA;
    W1_VALID = 1; W1_ADDR = 11'd11; W1_DATA = 16'hBBBB;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_w0_ready", 16'(W0_READY), 16'(exp_w0[i]));
      chk("cont_w1_ready", 16'(W1_READY), 16'(!exp_w0[i]));
      chk("cont_wdata", RAM_WDATA, exp_w0[i] ? 16'hAAAA : 16'hBBBB);
      tick();
    end
    W0_VALID = 0; W1_VALID = 0;
    // back-to-back reads 5,6,7 with R_READY high
    R_READY = 1; AR_VALID = 1; AR_ADDR = 11'd5;
    #1;
    chk("b2b_arready0", 16'(AR_READY), 16'h1);
    chk("b2b_araddr0", 16'(RAM_ARADDR), 16'h5);
    tick();
    AR_ADDR = 11'd6;
    #1;
    chk("b2b_c1_rvalid", 16'(R_VALID), 16'h0);
    chk("b2b_arready1", 16'(RAM_ARVALID), 16'h1);
    tick();
    AR_ADDR = 11'd7;
    #1;
    chk("b2b_c2_rvalid", 16'(R_VALID), 16'h1);
    chk("b2b_c2_rdata", R_DATA, 16'h1005);
    chk("b2b_arready2", 16'(RAM_ARVALID), 16'h1);
    tick();
    AR_VALID = 0;
    #1;
    chk("b2b_c3_rdata", R_DATA, 16'h1006);
    tick();
    #1;
    chk("b2b_c4_rvalid", 16'(R_VALID), 16'h1);
    chk("b2b_c4_rdata", R_DATA, 16'h1007);
    tick();
    #1;
    chk("b2b_c5_rvalid", 16'(R_VALID), 16'h0);
    // backpressure: only two reads accepted
    R_READY = 0; AR_VALID = 1; AR_ADDR = 11'd20;
    #1;
    chk("bp_acc0", 16'(AR_READY), 16'h1);
    tick();
    AR_ADDR = 11'd21;
    #1;
    chk("bp_acc1", 16'(AR_READY), 16'h1);
    tick();
    AR_ADDR = 11'd22;
    #1;
    chk("bp_block0", 16'(AR_READY), 16'h0);
    chk("bp_block0_arv", 16'(RAM_ARVALID), 16'h0);
    tick();
    #1;
    chk("bp_block1", 16'(AR_READY), 16'h0);
    chk("bp_hold_data", R_DATA, 16'h1014);
    R_READY = 1;
    #1;
    chk("bp_release", 16'(AR_READY), 16'h1);
    chk("bp_head0", R_DATA, 16'h1014);
    tick();
    AR_VALID = 0;
    #1;
    chk("bp_head1", R_DATA, 16'h1015);
    tick();
    #1;
    chk("bp_head2_v", 16'(R_VALID), 16'h1);
    chk("bp_head2", R_DATA, 16'h1016);
    tick();
    #1;
    chk("bp_empty", 16'(R_VALID), 16'h0);
    // collision: write and read to address 9 in the same cycle
    W0_VALID = 1; W0_ADDR = 11'd9; W0_DATA = 16'hABCD;
    AR_VALID = 1; AR_ADDR = 11'd9;
    #1;
    chk("col_arready", 16'(AR_READY), 16'h0);
    chk("col_wvalid", 16'(RAM_WVALID), 16'h1);
    tick();
    W0_VALID = 0;
    #1;
    chk("col_next_arready", 16'(AR_READY), 16'h1);
    tick();
    AR_VALID = 0;
    #1;
    chk("col_lat1", 16'(R_VALID), 16'h0);
    tick();
    #1;
    chk("col_rvalid", 16'(R_VALID), 16'h1);
    chk("col_rdata", R_DATA, 16'hABCD);
    tick();
    // reset right after an AR handshake
    AR_VALID = 1; AR_ADDR = 11'd5;
    #1;
    chk("rsf_arready", 16'(AR_READY), 16'h1);
    tick();
    AR_VALID = 0; RESET = 1;
    tick();
    RESET = 0;
    #1;
    chk("rsf_rvalid0", 16'(R_VALID), 16'h0);
    tick();
    #1;
    chk("rsf_rvalid1", 16'(R_VALID), 16'h0);
    chk("rsf_arready_after", 16'(AR_READY), 16'h1);
    // spurious RAM_RVALID with nothing outstanding
    spur = 1;
    tick();
    spur = 0;
    #1;
    chk("spur_rvalid", 16'(R_VALID), 16'h0);
    tick();
    #1;
    chk("spur_rvalid1", 16'(R_VALID), 16'h0);
    chk("spur_rdata", R_DATA, 16'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
